// File: rtl/pkt_fifo_cpu_buf_pkg.sv
// Shared types for the packet buffer: FSM encoding, error flag bit positions
// and the packet framing helper used on both the input and output sides.
package pkt_fifo_cpu_buf_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_CPU   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int ERR_OVF  = 0;
  localparam int ERR_COLL = 1;

  // A ctrl==0 word opens a packet body; any ctrl!=0 word closes it (EOP) or stays outside.
  function automatic logic body_next(input logic body, input logic valid, input logic ctrl_zero);
    logic nxt;
    if (valid) nxt = ctrl_zero;
    else       nxt = body;
    return nxt;
  endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Packet storage: one synchronous write port and two asynchronous read ports
// (datapath head and CPU inspection address).
module pkt_fifo_ram #(
  parameter int WIDTH      = 72,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  output logic [WIDTH-1:0]      rdata_a_o,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [WIDTH-1:0]      rdata_b_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/pkt_fifo_cpu_buf.sv
// Circular packet buffer with stream and hold modes; in hold mode one packet
// is parked for CPU inspection/rewrite and drained when software releases it.
module pkt_fifo_cpu_buf
  import pkt_fifo_cpu_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int CTRL_WIDTH   = DATA_WIDTH/8,
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  input  logic                             in_wr,
  output logic                             in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic                             cpu_hold_en,
  input  logic                             cpu_release,
  input  logic                             cpu_wen,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_wr_data,
  output logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_rd_data,
  output logic [ADDR_WIDTH-1:0]            head_addr,
  output logic [ADDR_WIDTH-1:0]            tail_addr,
  output logic [ADDR_WIDTH:0]              count,
  output logic [1:0]                       state,
  output logic [1:0]                       err_flags
);

  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_C = (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = CTRL_WIDTH'(0);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   head_q, head_d, tail_q, tail_d, cpu_waddr_q;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [1:0]              err_q;
  logic [WW-1:0]           cpu_rd_q, cpu_wdata_q, head_word_s, cpu_word_s;
  logic                    in_body_q, out_body_q, rel_prev_q, wen_prev_q, cpu_pend_q;
  logic                    full_s, wr_acc_s, ovf_s, out_en_s, out_wr_s;
  logic                    in_eop_s, out_eop_s, rel_rise_s, wen_rise_s;
  logic                    coll_s, cpu_issue_s, ram_we_s;
  logic [ADDR_WIDTH-1:0]   ram_waddr_s;
  logic [WW-1:0]           ram_wdata_s;

  pkt_fifo_ram #(.WIDTH(WW), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk       (clk),
    .we_i      (ram_we_s),
    .waddr_i   (ram_waddr_s),
    .wdata_i   (ram_wdata_s),
    .raddr_a_i (head_q),
    .rdata_a_o (head_word_s),
    .raddr_b_i (cpu_addr),
    .rdata_b_o (cpu_word_s)
  );

  always_comb begin
    full_s      = (count_q == DEPTH_C);
    wr_acc_s    = in_wr && !full_s;
    ovf_s       = in_wr && full_s;
    out_en_s    = (state_q == ST_DRAIN) || ((state_q == ST_FILL) && !cpu_hold_en);
    out_wr_s    = out_rdy && (count_q != CNT_ZERO) && out_en_s;
    in_eop_s    = wr_acc_s && in_body_q && (in_ctrl != CTRL_ZERO);
    out_eop_s   = out_wr_s && out_body_q && (head_word_s[WW-1:DATA_WIDTH] != CTRL_ZERO);
    rel_rise_s  = cpu_release && !rel_prev_q;
    wen_rise_s  = cpu_wen && !wen_prev_q;
    // The datapath always owns the write port; a pending CPU write waits, or dies on the same address.
    coll_s      = cpu_pend_q && wr_acc_s && (tail_q == cpu_waddr_q);
    cpu_issue_s = cpu_pend_q && !wr_acc_s;
    ram_we_s    = wr_acc_s || cpu_issue_s;
    if (wr_acc_s) begin
      ram_waddr_s = tail_q;
      ram_wdata_s = {in_ctrl, in_data};
    end else begin
      ram_waddr_s = cpu_waddr_q;
      ram_wdata_s = cpu_wdata_q;
    end
    head_d = out_wr_s ? head_q + PTR_ONE : head_q;
    tail_d = wr_acc_s ? tail_q + PTR_ONE : tail_q;
    case ({wr_acc_s, out_wr_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q      <= ADDR_WIDTH'(0);
      tail_q      <= ADDR_WIDTH'(0);
      count_q     <= CNT_ZERO;
      err_q       <= 2'b00;
      cpu_rd_q    <= WW'(0);
      in_body_q   <= 1'b0;
      out_body_q  <= 1'b0;
      rel_prev_q  <= 1'b0;
      wen_prev_q  <= 1'b0;
      cpu_pend_q  <= 1'b0;
      cpu_waddr_q <= ADDR_WIDTH'(0);
      cpu_wdata_q <= WW'(0);
    end else begin
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      err_q[ERR_OVF]     <= err_q[ERR_OVF] | ovf_s;
      err_q[ERR_COLL]    <= err_q[ERR_COLL] | coll_s;
      cpu_rd_q           <= cpu_word_s;
      in_body_q          <= body_next(in_body_q, wr_acc_s, in_ctrl == CTRL_ZERO);
      out_body_q         <= body_next(out_body_q, out_wr_s,
                                      head_word_s[WW-1:DATA_WIDTH] == CTRL_ZERO);
      rel_prev_q         <= cpu_release;
      wen_prev_q         <= cpu_wen;
      if (wen_rise_s) begin
        cpu_pend_q  <= 1'b1;
        cpu_waddr_q <= cpu_addr;
        cpu_wdata_q <= cpu_wr_data;
      end else if (cpu_issue_s || coll_s) begin
        cpu_pend_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FILL;
    end else begin
      case (state_q)
        ST_FILL:  if (cpu_hold_en && in_eop_s)      state_q <= ST_CPU;
        ST_CPU:   if (!cpu_hold_en || rel_rise_s)   state_q <= ST_DRAIN;
        ST_DRAIN: if (out_eop_s)                    state_q <= ST_FILL;
        default:                                    state_q <= ST_FILL;
      endcase
    end
  end

  assign in_rdy      = (count_q < AFULL_C) && (state_q == ST_FILL);
  assign out_wr      = out_wr_s;
  assign out_data    = head_word_s[DATA_WIDTH-1:0];
  assign out_ctrl    = head_word_s[WW-1:DATA_WIDTH];
  assign cpu_rd_data = cpu_rd_q;
  assign head_addr   = head_q;
  assign tail_addr   = tail_q;
  assign count       = count_q;
  assign state       = state_q;
  assign err_flags   = err_q;

endmodule
